// File: rtl/serial_adder_pkg.sv
// -----------------------------------------------------------------------------
// serial_adder_pkg
//   Shared types and helpers for the bit-serial adder.
//   - state_e   : controller state encoding (IDLE / RUN / DONE)
//   - cnt_width : width of the bit counter; it must be able to hold WIDTH
// -----------------------------------------------------------------------------
package serial_adder_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  function automatic int cnt_width(input int width);
    return $clog2(width + 1);
  endfunction

endpackage : serial_adder_pkg

// File: rtl/adder_full.sv
// -----------------------------------------------------------------------------
// half_adder / adder_full
//   Combinational 1-bit adder cells used by the bit-serial adder.
//   half_adder : a, b         -> sum = a^b, carry = a&b
//   adder_full : a, b, cin    -> sum, cout, built from two half adders plus an
//                OR of their carries. It has no state; the carry flop that
//                links successive bits lives in the parent.
// -----------------------------------------------------------------------------
module half_adder (
  input  logic a,
  input  logic b,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b;
  assign carry = a & b;

endmodule : half_adder

module adder_full (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic cout
);

  logic ab_sum;
  logic ab_carry;
  logic abc_carry;

  half_adder u_ha_ab (
    .a     (a),
    .b     (b),
    .sum   (ab_sum),
    .carry (ab_carry)
  );

  half_adder u_ha_abc (
    .a     (ab_sum),
    .b     (cin),
    .sum   (sum),
    .carry (abc_carry)
  );

  // The two half-adder carries can never both be 1, so OR equals majority.
  assign cout = ab_carry | abc_carry;

endmodule : adder_full

// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//   Bit-serial adder: loads two WIDTH-bit operands on an accepted start, then
//   adds them LSB-first, one bit per clock, through a single full-adder cell.
//   The parallel sum and final carry are presented with a start/busy/done
//   handshake and held until the next accepted start.
//
//   Parameters
//     WIDTH      operand / sum width in bits (>= 1)
//   Ports
//     clk        rising-edge clock
//     rst        synchronous, active-high reset
//     start      request, sampled only in IDLE
//     cin        carry-in, captured on the accepting edge
//                (present only when SERIAL_ADDER_CIN_EN is defined)
//     a, b       operands, captured on the accepting edge
//     busy       high while in RUN
//     done       one-cycle pulse; sum / carry_out are valid while high
//     sum        result, cleared on the accepting edge, final after DONE
//     carry_out  final carry, updated only when a new result completes
//
//   Build option
//     SERIAL_ADDER_CIN_EN : adds the cin port; result = a + b + cin.
//                           Undefined: the carry flop starts at 0.
// -----------------------------------------------------------------------------
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
`ifdef SERIAL_ADDER_CIN_EN
  input  logic             cin,
`endif
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out
);

  localparam int                CNT_W    = cnt_width(WIDTH);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(WIDTH - 1);

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   sa_q, sa_d;
  logic [WIDTH-1:0]   sb_q, sb_d;
  logic [WIDTH-1:0]   sum_q, sum_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic               carry_init;
  logic               fa_sum;
  logic               fa_cout;
  logic               last_bit;

`ifdef SERIAL_ADDER_CIN_EN
  assign carry_init = cin;
`else
  assign carry_init = 1'b0;
`endif

  assign last_bit = (cnt_q == CNT_LAST);

  adder_full u_fa (
    .a    (sa_q[0]),
    .b    (sb_q[0]),
    .cin  (carry_q),
    .sum  (fa_sum),
    .cout (fa_cout)
  );

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state is written with <= only, so every flop samples the
  // pre-edge values of the others regardless of block ordering.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can leave a
  // signal unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start)    state_d = RUN;
      RUN:     if (last_bit) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // FSM: outputs, decoded straight from the state register
  // ---------------------------------------------------------------------------
  always_comb begin
    busy = (state_q == RUN);
    done = (state_q == DONE);
  end

  // ---------------------------------------------------------------------------
  // Datapath next-state
  // ---------------------------------------------------------------------------
  always_comb begin
    sa_d    = sa_q;
    sb_d    = sb_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          sa_d    = a;
          sb_d    = b;
          carry_d = carry_init;
          sum_d   = '0;
          cnt_d   = '0;
        end
      end
      RUN: begin
        sa_d  = sa_q >> 1;
        sb_d  = sb_q >> 1;
        // Result bits enter at the MSB so after WIDTH shifts bit 0 sits at
        // position 0. Written as shift + bit set so WIDTH=1 stays legal.
        sum_d              = sum_q >> 1;
        sum_d[WIDTH-1]     = fa_sum;
        carry_d            = fa_cout;
        cnt_d              = cnt_q + CNT_W'(1);
        if (last_bit) cout_d = fa_cout;
      end
      default: ;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath registers
  // ---------------------------------------------------------------------------
  // NOTE: the operand shift registers are ordinary flops, not a memory, so
  // they are cleared by reset along with everything else.
  always_ff @(posedge clk) begin
    if (rst) begin
      sa_q    <= '0;
      sb_q    <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  assign sum       = sum_q;
  assign carry_out = cout_q;

endmodule : serial_adder

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//   Scoreboard bench for serial_adder. Two instances share the clock: an
//   8-bit one (u_dut) and a 1-bit one (u_dut1). Stimulus pushes hand-computed
//   {carry_out, sum} values into a per-instance queue; a monitor per instance
//   pops and compares whenever done is high.
// -----------------------------------------------------------------------------
module tb_serial_adder;

  logic       clk = 1'b0;
  logic       rst;

  // 8-bit instance
  logic       start;
  logic [7:0] a, b;
  logic       busy, done;
  logic [7:0] sum;
  logic       carry_out;
`ifdef SERIAL_ADDER_CIN_EN
  logic       cin;
  logic       cin1;
`endif

  // 1-bit instance
  logic       start1;
  logic [0:0] a1, b1;
  logic       busy1, done1;
  logic [0:0] sum1;
  logic       cout1;

  int n_tests = 0;
  int n_fail  = 0;
  int done_cnt = 0;

  logic [8:0] q0[$];
  logic [1:0] q1[$];

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(8)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
`ifdef SERIAL_ADDER_CIN_EN
    .cin       (cin),
`endif
    .a         (a),
    .b         (b),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .carry_out (carry_out)
  );

  serial_adder #(.WIDTH(1)) u_dut1 (
    .clk       (clk),
    .rst       (rst),
    .start     (start1),
`ifdef SERIAL_ADDER_CIN_EN
    .cin       (cin1),
`endif
    .a         (a1),
    .b         (b1),
    .busy      (busy1),
    .done      (done1),
    .sum       (sum1),
    .carry_out (cout1)
  );

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Monitors
  // ---------------------------------------------------------------------------
  logic prev_done = 1'b0;

  always @(negedge clk) begin
    if (done) begin
      logic [8:0] e;
      done_cnt++;
      check("done_not_consecutive", {31'd0, prev_done}, 32'd0);
      check("q0_has_entry", {31'd0, q0.size() != 0}, 32'd1);
      if (q0.size() != 0) begin
        e = q0.pop_front();
        check("sum", {24'd0, sum}, {24'd0, e[7:0]});
        check("carry_out", {31'd0, carry_out}, {31'd0, e[8]});
      end
    end
    check("busy_done_exclusive", {31'd0, busy & done}, 32'd0);
    prev_done = done;
  end

  always @(negedge clk) begin
    if (done1) begin
      logic [1:0] e;
      check("q1_has_entry", {31'd0, q1.size() != 0}, 32'd1);
      if (q1.size() != 0) begin
        e = q1.pop_front();
        check("w1_sum", {31'd0, sum1}, {31'd0, e[0]});
        check("w1_carry_out", {31'd0, cout1}, {31'd0, e[1]});
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  // Issue one operation and wait for done. Index 0 is the cycle after the
  // accepting edge; done is expected at index WIDTH. With poke set, start is
  // pulsed with a=0x33 at RUN indices 2 and 4 (must be ignored).
  task automatic run_op(input logic [7:0] ta, input logic [7:0] tb_v, input logic tcin,
                        input logic [7:0] exp_sum, input logic exp_c, input bit poke,
                        input string tag);
    int  lat    = 99;
    int  n_busy = 0;
    @(negedge clk);
    a = ta; b = tb_v; start = 1'b1;
`ifdef SERIAL_ADDER_CIN_EN
    cin = tcin;
`endif
    q0.push_back({exp_c, exp_sum});
    @(negedge clk);
    start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (done) begin
        lat = i;
        break;
      end
      if (busy) n_busy++;
      if (poke && (i == 2 || i == 4)) begin
        start = 1'b1;
        a     = 8'h33;
      end else begin
        start = 1'b0;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 32'd8);
    check({tag, "_busy_cycles"}, n_busy, 32'd8);
    @(negedge clk);
    check({tag, "_idle_after_done"}, {30'd0, busy, done}, 32'd0);
  endtask

  task automatic run_op1(input logic ta, input logic tb_v, input logic exp_s, input logic exp_c,
                         input string tag);
    int lat = 99;
    @(negedge clk);
    a1 = ta; b1 = tb_v; start1 = 1'b1;
    q1.push_back({exp_c, exp_s});
    @(negedge clk);
    start1 = 1'b0;
    for (int i = 0; i < 10; i++) begin
      if (done1) begin
        lat = i;
        break;
      end
      @(negedge clk);
    end
    check({tag, "_latency"}, lat, 32'd1);
    @(negedge clk);
  endtask

  // ---------------------------------------------------------------------------
  // Main sequence
  // ---------------------------------------------------------------------------
  initial begin
    int cnt_before;
    int idx[$];

    rst = 1'b1; start = 1'b0; a = '0; b = '0;
    start1 = 1'b0; a1 = '0; b1 = '0;
`ifdef SERIAL_ADDER_CIN_EN
    cin = 1'b0; cin1 = 1'b0;
`endif
    repeat (2) @(negedge clk);
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_sum", {24'd0, sum}, 32'd0);
    check("rst_carry_out", {31'd0, carry_out}, 32'd0);
    rst = 1'b0;

    // Basic adds.
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b0, "add_0f_01");

    // Starts during RUN ignored.
    cnt_before = done_cnt;
    run_op(8'h0F, 8'h01, 1'b0, 8'h10, 1'b0, 1'b1, "ignore_start");
    repeat (12) @(negedge clk);
    check("ignore_start_done_pulses", done_cnt - cnt_before, 32'd1);

    // Overflow, leaves carry_out=1 ahead of the reset test.
    run_op(8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0, "add_ff_01");
    check("sum_held_idle", {24'd0, sum}, 32'h00);
    check("carry_held_idle", {31'd0, carry_out}, 32'd1);

    // Reset mid-RUN at counter=3; the partial result is discarded.
    @(negedge clk);
    a = 8'h55; b = 8'h00; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    check("midrun_busy_before_rst", {31'd0, busy}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrun_rst_busy", {31'd0, busy}, 32'd0);
    check("midrun_rst_done", {31'd0, done}, 32'd0);
    check("midrun_rst_sum", {24'd0, sum}, 32'd0);
    check("midrun_rst_carry_out", {31'd0, carry_out}, 32'd0);
    run_op(8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b0, "add_80_80");

    run_op(8'hA5, 8'h5A, 1'b0, 8'hFF, 1'b0, 1'b0, "add_a5_5a");

    // Start held high for 30 cycles: accepts every 10 cycles.
    cnt_before = done_cnt;
    repeat (3) q0.push_back({1'b0, 8'h03});
    @(negedge clk);
    a = 8'h01; b = 8'h02; start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      if (done) idx.push_back(i);
    end
    start = 1'b0;
    repeat (12) @(negedge clk);
    check("hold_done_pulses", done_cnt - cnt_before, 32'd3);
    check("hold_pulse_count_in_window", idx.size(), 32'd3);
    if (idx.size() == 3) begin
      check("hold_first_done", idx[0], 32'd8);
      check("hold_gap_1", idx[1] - idx[0], 32'd10);
      check("hold_gap_2", idx[2] - idx[1], 32'd10);
    end

`ifdef SERIAL_ADDER_CIN_EN
    run_op(8'hFF, 8'h00, 1'b1, 8'h00, 1'b1, 1'b0, "cin_ff_00_1");
    run_op(8'h10, 8'h20, 1'b1, 8'h31, 1'b0, 1'b0, "cin_10_20_1");
`endif

    // WIDTH=1 instance.
    run_op1(1'b1, 1'b1, 1'b0, 1'b1, "w1_1_1");
    run_op1(1'b1, 1'b0, 1'b1, 1'b0, "w1_1_0");
    run_op1(1'b0, 1'b0, 1'b0, 1'b0, "w1_0_0");

    repeat (3) @(negedge clk);
    check("q0_drained", q0.size(), 32'd0);
    check("q1_drained", q1.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_serial_adder
